// File: rtl/i_execute_if.sv
// rtl/i_execute_if.sv - ID/EX input and EX/MEM output bundle of the execute stage
//
// Purpose: groups the ID/EX latch fields consumed by the execute stage, the
//          flush/stall hazard pair, and the EX/MEM latch fields it produces.
// Modports:
//   master - upstream/hazard side: drives ID_EX_* and flush, observes stall and EX_MEM_*
//   slave  - execute stage: consumes ID_EX_* and flush, drives stall and EX_MEM_*
interface i_execute_if;
   logic        flush;
   logic [1:0]  ID_EX_wb_ctl;
   logic [2:0]  ID_EX_m_ctl;
   logic        ID_EX_regdst;
   logic        ID_EX_alusrc;
   logic [1:0]  ID_EX_aluop;
   logic [31:0] ID_EX_npc;
   logic [31:0] ID_EX_readdat1;
   logic [31:0] ID_EX_readdat2;
   logic [31:0] ID_EX_sign_ext;
   logic [4:0]  ID_EX_instr_2016;
   logic [4:0]  ID_EX_instr_1511;

   logic        stall;
   logic [1:0]  EX_MEM_wb_ctl;
   logic [2:0]  EX_MEM_m_ctl;
   logic [31:0] EX_MEM_NPC;
   logic        EX_MEM_zero;
   logic [31:0] EX_MEM_alu_result;
   logic [31:0] EX_MEM_rdata2;
   logic [4:0]  EX_MEM_write_reg;
   logic        EX_MEM_PCSrc;

   modport master (
      output flush, ID_EX_wb_ctl, ID_EX_m_ctl, ID_EX_regdst, ID_EX_alusrc, ID_EX_aluop,
             ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext,
             ID_EX_instr_2016, ID_EX_instr_1511,
      input  stall, EX_MEM_wb_ctl, EX_MEM_m_ctl, EX_MEM_NPC, EX_MEM_zero,
             EX_MEM_alu_result, EX_MEM_rdata2, EX_MEM_write_reg, EX_MEM_PCSrc
   );

   modport slave (
      input  flush, ID_EX_wb_ctl, ID_EX_m_ctl, ID_EX_regdst, ID_EX_alusrc, ID_EX_aluop,
             ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext,
             ID_EX_instr_2016, ID_EX_instr_1511,
      output stall, EX_MEM_wb_ctl, EX_MEM_m_ctl, EX_MEM_NPC, EX_MEM_zero,
             EX_MEM_alu_result, EX_MEM_rdata2, EX_MEM_write_reg, EX_MEM_PCSrc
   );
endinterface

// File: rtl/i_execute.sv
// rtl/i_execute.sv - MIPS execute stage with EX/MEM latch and iterative multiplier
//
// Purpose: computes ALU result, zero flag, branch target and destination
//          register, and registers them into EX/MEM. A funct=011000 R-type
//          runs a MUL_CYCLES-step shift-add multiplier, stalling upstream.
// Ports:
//   clk - rising-edge pipeline clock
//   rst - synchronous active-high reset
//   ex  - i_execute_if.slave: ID/EX inputs, flush, stall, EX/MEM outputs
module i_execute #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input logic     clk,
   input logic     rst,
   i_execute_if.slave ex
);
   localparam int            CW   = $clog2(MUL_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

   typedef enum logic {IDLE, MUL} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mcand, mplr, acc;

   logic [1:0]       r_wb;
   logic [2:0]       r_m;
   logic [WIDTH-1:0] r_npc, r_res, r_rdata2;
   logic             r_zero;
   logic [4:0]       r_wr;

   logic [WIDTH-1:0] op_a, op_b, alu_res, br_target, acc_step;
   logic [5:0]       funct;
   logic [4:0]       write_reg;
   logic             is_mul, last_step;

   logic [1:0]       nxt_wb;
   logic [2:0]       nxt_m;
   logic [WIDTH-1:0] nxt_npc, nxt_res, nxt_rdata2;
   logic             nxt_zero;
   logic [4:0]       nxt_wr;

   assign op_a      = ex.ID_EX_readdat1;
   assign op_b      = ex.ID_EX_alusrc ? ex.ID_EX_sign_ext : ex.ID_EX_readdat2;
   assign funct     = ex.ID_EX_sign_ext[5:0];
   assign write_reg = ex.ID_EX_regdst ? ex.ID_EX_instr_1511 : ex.ID_EX_instr_2016;
   assign br_target = ex.ID_EX_npc + (ex.ID_EX_sign_ext << 2);
   assign is_mul    = (ex.ID_EX_aluop == 2'b10) && (funct == 6'b011000) && !ex.flush;
   assign last_step = (state == MUL) && (count == LAST);
   // Accumulator value after this cycle's step; the final step feeds EX/MEM directly.
   assign acc_step  = acc + (mplr[0] ? mcand : '0);

   assign ex.stall = !rst && !ex.flush &&
                     (((state == IDLE) && is_mul) || ((state == MUL) && !last_step));

   always_comb begin
      alu_res = '0;
      case (ex.ID_EX_aluop)
         2'b01: alu_res = op_a - op_b;
         2'b10: begin
            case (funct)
               6'b100000: alu_res = op_a + op_b;
               6'b100010: alu_res = op_a - op_b;
               6'b100100: alu_res = op_a & op_b;
               6'b100101: alu_res = op_a | op_b;
               6'b101010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
               // mul result comes from the iterative unit; unknown funct yields 0
               default:   alu_res = '0;
            endcase
         end
         default: alu_res = op_a + op_b;
      endcase
   end

   // Next EX/MEM contents: a bubble unless a non-mul retires from IDLE or the multiply completes.
   always_comb begin
      nxt_wb     = '0;
      nxt_m      = '0;
      nxt_npc    = '0;
      nxt_res    = '0;
      nxt_rdata2 = '0;
      nxt_zero   = 1'b0;
      nxt_wr     = '0;
      if (!ex.flush && (((state == IDLE) && !is_mul) || last_step)) begin
         nxt_wb     = ex.ID_EX_wb_ctl;
         nxt_m      = ex.ID_EX_m_ctl;
         nxt_npc    = br_target;
         nxt_rdata2 = ex.ID_EX_readdat2;
         nxt_wr     = write_reg;
         nxt_res    = last_step ? acc_step : alu_res;
         nxt_zero   = (nxt_res == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplr     <= '0;
         r_wb     <= '0;
         r_m      <= '0;
         r_npc    <= '0;
         r_res    <= '0;
         r_rdata2 <= '0;
         r_zero   <= 1'b0;
         r_wr     <= '0;
      end else begin
         r_wb     <= nxt_wb;
         r_m      <= nxt_m;
         r_npc    <= nxt_npc;
         r_res    <= nxt_res;
         r_rdata2 <= nxt_rdata2;
         r_zero   <= nxt_zero;
         r_wr     <= nxt_wr;
         if (ex.flush) begin
            state <= IDLE;
            count <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (is_mul) begin
                     mcand <= op_a;
                     mplr  <= op_b;
                     acc   <= '0;
                     count <= '0;
                     state <= MUL;
                  end
               end
               MUL: begin
                  acc   <= acc_step;
                  mcand <= mcand << 1;
                  mplr  <= mplr >> 1;
                  count <= count + CW'(1);
                  if (last_step)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign ex.EX_MEM_wb_ctl     = r_wb;
   assign ex.EX_MEM_m_ctl      = r_m;
   assign ex.EX_MEM_NPC        = r_npc;
   assign ex.EX_MEM_zero       = r_zero;
   assign ex.EX_MEM_alu_result = r_res;
   assign ex.EX_MEM_rdata2     = r_rdata2;
   assign ex.EX_MEM_write_reg  = r_wr;
   assign ex.EX_MEM_PCSrc      = r_m[2] & r_zero;
endmodule
